// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, optional two-entry skid buffer,
// flush and all-zero bubble insertion, plus a saturating stall counter.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CTRL_W = 3,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              CLR,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       IR_in,
    input  logic [31:0]       PC_in,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       IR,
    output logic [31:0]       PC,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int unsigned EntW = 64 + DATA_W + CTRL_W;

    logic [EntW-1:0]  in_ent;
    logic [EntW-1:0]  m_q, m_d, s_q, s_d;
    logic             m_valid_q, m_valid_d, s_valid_q, s_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, m_free;

    assign in_ent = {IR_in, PC_in, data_in, ctrl_in};

    // With the skid buffer, in_ready depends only on registered state.
    assign in_ready = (SKID != 0) ? ~s_valid_q : (~m_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign m_free   = ~m_valid_q | out_ready;

    always_comb begin
        m_d       = m_q;
        m_valid_d = m_valid_q;
        s_d       = s_q;
        s_valid_d = s_valid_q;
        cnt_d     = cnt_q;
        if (flush) begin
            m_d       = '0;
            m_valid_d = 1'b0;
            s_d       = '0;
            s_valid_d = 1'b0;
        end else begin
            if (m_valid_q && !out_ready && (cnt_q != '1)) begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (m_free) begin
                if (s_valid_q) begin
                    m_d       = s_q;
                    m_valid_d = 1'b1;
                    s_d       = '0;
                    s_valid_d = 1'b0;
                end else if (accept) begin
                    m_d       = in_ent;
                    m_valid_d = 1'b1;
                end else begin
                    m_d       = '0;
                    m_valid_d = 1'b0;
                end
            end else if (accept && (SKID != 0)) begin
                s_d       = in_ent;
                s_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            m_q       <= '0;
            m_valid_q <= 1'b0;
            s_q       <= '0;
            s_valid_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            m_q       <= m_d;
            m_valid_q <= m_valid_d;
            s_q       <= s_d;
            s_valid_q <= s_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    // Fields of an invalid entry are always zero, so outputs come straight from M.
    assign out_valid         = m_valid_q;
    assign {IR, PC, data, ctrl} = m_q;
    assign stall_cnt         = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench: skid-buffered instance with default widths, plus a SKID=0, CNT_W=4 instance.
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        CLR, flush, in_valid, out_ready;
    logic [31:0] IR_in, PC_in, data_in;
    logic [2:0]  ctrl_in;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_IR, a_PC, a_data;
    logic [2:0]  a_ctrl;
    logic [15:0] a_cnt;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_IR, b_PC, b_data;
    logic [2:0]  b_ctrl;
    logic [3:0]  b_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID(1), .CNT_W(16)) u_skid (
        .clk(clk), .CLR(CLR), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .IR_in(IR_in), .PC_in(PC_in), .data_in(data_in), .ctrl_in(ctrl_in),
        .out_valid(a_out_valid), .out_ready(out_ready), .IR(a_IR), .PC(a_PC),
        .data(a_data), .ctrl(a_ctrl), .stall_cnt(a_cnt)
    );

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(3), .SKID(0), .CNT_W(4)) u_noskid (
        .clk(clk), .CLR(CLR), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .IR_in(IR_in), .PC_in(PC_in), .data_in(data_in), .ctrl_in(ctrl_in),
        .out_valid(b_out_valid), .out_ready(out_ready), .IR(b_IR), .PC(b_PC),
        .data(b_data), .ctrl(b_ctrl), .stall_cnt(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [2:0] c);
        in_valid = v;
        PC_in    = pc;
        IR_in    = pc ^ 32'hA500_0000;
        data_in  = pc + 32'd7;
        ctrl_in  = c;
    endtask

    initial begin
        CLR = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b1, 32'h100, 3'b111);
        step();
        step();
        check_eq("rst_a_valid", a_out_valid, 0);
        check_eq("rst_a_ctrl", a_ctrl, 0);
        check_eq("rst_a_cnt", a_cnt, 0);
        check_eq("rst_b_valid", b_out_valid, 0);
        check_eq("rst_b_ctrl", b_ctrl, 0);
        CLR = 1'b0;
        drive(1'b0, 32'h0, 3'b000);
        #1;
        check_eq("rst_a_ready", a_in_ready, 1);
        check_eq("rst_b_ready", b_in_ready, 1);

        // Streaming through the skid instance, one entry per cycle.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(4 * i), 3'(i));
            step();
            check_eq($sformatf("stream_valid%0d", i), a_out_valid, 1);
            check_eq($sformatf("stream_pc%0d", i), a_PC, 64'(4 * i));
            check_eq($sformatf("stream_ir%0d", i), a_IR, 64'((4 * i) ^ 32'hA500_0000));
        end
        drive(1'b0, 32'h0, 3'b000);
        step();
        check_eq("bubble_a_valid", a_out_valid, 0);
        check_eq("bubble_a_pc", a_PC, 0);

        // Back-pressure with skid absorption.
        drive(1'b1, 32'h10, 3'b001);
        step();
        check_eq("bp_pc10", a_PC, 32'h10);
        out_ready = 1'b0;
        drive(1'b1, 32'h14, 3'b010);
        step();
        check_eq("bp_hold10", a_PC, 32'h10);
        check_eq("bp_ready0", a_in_ready, 0);
        drive(1'b1, 32'h18, 3'b011);
        step();
        step();
        step();
        check_eq("bp_cnt4", a_cnt, 4);
        check_eq("bp_still10", a_PC, 32'h10);
        check_eq("bp_still_ready0", a_in_ready, 0);
        out_ready = 1'b1;
        step();
        check_eq("bp_pc14", a_PC, 32'h14);
        check_eq("bp_ready1", a_in_ready, 1);
        check_eq("bp_cnt_hold", a_cnt, 4);
        step();
        check_eq("bp_pc18", a_PC, 32'h18);
        check_eq("bp_ctrl18", a_ctrl, 3'b011);

        // Flush with M and S both full.
        out_ready = 1'b0;
        drive(1'b1, 32'h20, 3'b101);
        step();
        check_eq("fl_full_ready0", a_in_ready, 0);
        check_eq("fl_cnt5", a_cnt, 5);
        flush = 1'b1;
        drive(1'b1, 32'h24, 3'b110);
        step();
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'b000);
        check_eq("fl_valid", a_out_valid, 0);
        check_eq("fl_ir", a_IR, 0);
        check_eq("fl_pc", a_PC, 0);
        check_eq("fl_data", a_data, 0);
        check_eq("fl_ctrl", a_ctrl, 0);
        check_eq("fl_ready", a_in_ready, 1);
        check_eq("fl_cnt", a_cnt, 5);
        out_ready = 1'b1;
        step();
        check_eq("fl_nothing_left", a_out_valid, 0);

        // SKID=0 instance: bubble, combinational ready, stall ordering.
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        check_eq("b_clr_cnt", b_cnt, 0);
        check_eq("b_clr_valid", b_out_valid, 0);
        drive(1'b1, 32'h40, 3'b101);
        step();
        check_eq("b_valid40", b_out_valid, 1);
        check_eq("b_pc40", b_PC, 32'h40);
        check_eq("b_data40", b_data, 32'h47);
        drive(1'b0, 32'h0, 3'b000);
        step();
        check_eq("b_bub_valid", b_out_valid, 0);
        check_eq("b_bub_ir", b_IR, 0);
        check_eq("b_bub_pc", b_PC, 0);
        check_eq("b_bub_data", b_data, 0);
        check_eq("b_bub_ctrl", b_ctrl, 0);
        drive(1'b1, 32'h44, 3'b001);
        step();
        drive(1'b0, 32'h0, 3'b000);
        out_ready = 1'b0;
        #1;
        check_eq("b_ready_follow0", b_in_ready, 0);
        out_ready = 1'b1;
        #1;
        check_eq("b_ready_follow1", b_in_ready, 1);
        out_ready = 1'b0;
        drive(1'b1, 32'h48, 3'b010);
        step();
        check_eq("b_hold44", b_PC, 32'h44);
        check_eq("b_cnt1", b_cnt, 1);
        out_ready = 1'b1;
        step();
        check_eq("b_pc48", b_PC, 32'h48);
        check_eq("b_ctrl48", b_ctrl, 3'b010);

        // Saturation of the 4-bit counter.
        drive(1'b0, 32'h0, 3'b000);
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check_eq("b_sat15", b_cnt, 15);
        step();
        check_eq("b_sat_hold", b_cnt, 15);
        check_eq("b_sat_pc", b_PC, 32'h48);
        CLR = 1'b1;
        step();
        CLR = 1'b0;
        check_eq("b_sat_clr", b_cnt, 0);
        check_eq("b_sat_clr_valid", b_out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
